// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator keypad front end and calc_top.
//   - 4-bit command codes (digits, operators, clear, equals, idle)
//   - keypad FSM state enum
//   - key_code(): maps a (row, col) keypad position to its command code
package calc_pkg;

    localparam logic [3:0] CMD_D0   = 4'd0;
    localparam logic [3:0] CMD_D1   = 4'd1;
    localparam logic [3:0] CMD_D2   = 4'd2;
    localparam logic [3:0] CMD_D3   = 4'd3;
    localparam logic [3:0] CMD_D4   = 4'd4;
    localparam logic [3:0] CMD_D5   = 4'd5;
    localparam logic [3:0] CMD_D6   = 4'd6;
    localparam logic [3:0] CMD_D7   = 4'd7;
    localparam logic [3:0] CMD_D8   = 4'd8;
    localparam logic [3:0] CMD_D9   = 4'd9;
    localparam logic [3:0] CMD_ADD  = 4'b1010;
    localparam logic [3:0] CMD_SUB  = 4'b1011;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_CLR  = 4'b1101;
    localparam logic [3:0] CMD_EQ   = 4'b1110;
    localparam logic [3:0] CMD_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    // Physical layout:  c0 c1 c2 c3
    //               r0:  1  2  3  A
    //               r1:  4  5  6  B
    //               r2:  7  8  9  C
    //               r3:  D  0  E  -   (r3/c3 unused -> CMD_IDLE)
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = CMD_D1;
            4'h1: code = CMD_D2;
            4'h2: code = CMD_D3;
            4'h3: code = CMD_ADD;
            4'h4: code = CMD_D4;
            4'h5: code = CMD_D5;
            4'h6: code = CMD_D6;
            4'h7: code = CMD_SUB;
            4'h8: code = CMD_D7;
            4'h9: code = CMD_D8;
            4'hA: code = CMD_D9;
            4'hB: code = CMD_MUL;
            4'hC: code = CMD_CLR;
            4'hD: code = CMD_D0;
            4'hE: code = CMD_EQ;
            default: code = CMD_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/calc_sync2.sv
// calc_sync2: two-flop synchronizer for asynchronous inputs.
//   i_clk   : destination clock
//   i_rst_n : async active-low reset, flops load RST_VAL
//   i_d     : asynchronous input bus
//   o_q     : synchronized output (2-clock latency)
module calc_sync2 #(
    parameter int          WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/calc_keypad.sv
// calc_keypad: 4x4 matrix keypad scanner with debounce, producing one
// calculator command per key press.
//   i_clk       : system clock, rising edge
//   i_rst_n     : async active-low reset
//   i_rows      : row lines, active-low, asynchronous to i_clk
//   o_cols      : column drive, one-hot active-low
//   o_cmd       : command code, CMD_IDLE when nothing is emitted (registered)
//   o_cmd_valid : one-clock pulse on the first cycle of a new code (registered)
module calc_keypad
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic [3:0] o_cmd,
    output logic       o_cmd_valid
);

    localparam int CNT_MAX_A = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > HOLD_CYCLES) ? CNT_MAX_A : HOLD_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    kp_state_e       r_state, w_state_nxt;
    logic [1:0]      r_col;
    logic [1:0]      r_row;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_cmd;
    logic            r_cmd_valid;

    logic [3:0]      w_rows_s;
    logic [2:0]      w_n_low;
    logic [1:0]      w_low_idx;
    logic            w_single_low;
    logic            w_row_held;
    logic            w_all_high;
    logic            w_scan_done;
    logic            w_deb_done;
    logic            w_hold_done;
    logic [3:0]      w_code;
    logic [3:0]      w_cmd_nxt;
    logic            w_valid_nxt;

    // Idle keypad reads all-high, so the synchronizer resets to ones.
    calc_sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rows),
        .o_q     (w_rows_s)
    );

    // Count low rows; only a single low row identifies a key unambiguously.
    always_comb begin
        w_n_low   = 3'd0;
        w_low_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!w_rows_s[i]) begin
                w_n_low   = w_n_low + 3'd1;
                w_low_idx = 2'(i);
            end
        end
    end

    assign w_single_low = (w_n_low == 3'd1);
    assign w_row_held   = (w_rows_s == ~(4'b0001 << r_row));
    assign w_all_high   = &w_rows_s;
    assign w_scan_done  = (r_cnt == CW'(SCAN_CYCLES - 1));
    assign w_deb_done   = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_hold_done  = (r_cnt == CW'(HOLD_CYCLES - 1));
    assign w_code       = key_code(r_row, r_col);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_SCAN;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN:
                if (w_single_low) w_state_nxt = ST_DEBOUNCE;
            ST_DEBOUNCE:
                if (!w_row_held)     w_state_nxt = ST_SCAN;
                // The unused key has no code: skip straight to waiting for release.
                else if (w_deb_done) w_state_nxt = (w_code == CMD_IDLE) ? ST_RELEASE : ST_EMIT;
            ST_EMIT:
                if (w_hold_done) w_state_nxt = ST_RELEASE;
            ST_RELEASE:
                if (w_all_high && w_deb_done) w_state_nxt = ST_SCAN;
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    // Output logic: next values of the registered outputs. The code is
    // loaded on entry to EMIT and held until EMIT is left; row activity
    // during EMIT is ignored so an early release cannot shorten the hold.
    always_comb begin
        w_cmd_nxt   = CMD_IDLE;
        w_valid_nxt = 1'b0;
        if (w_state_nxt == ST_EMIT) begin
            w_cmd_nxt   = (r_state == ST_EMIT) ? r_cmd : w_code;
            w_valid_nxt = (r_state != ST_EMIT);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd       <= CMD_IDLE;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd       <= w_cmd_nxt;
            r_cmd_valid <= w_valid_nxt;
        end
    end

    // Counter, column and latched row. One shared counter serves scan
    // dwell, press/release debounce and command hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_col <= 2'd0;
            r_row <= 2'd0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_single_low) begin
                        r_row <= w_low_idx;
                        r_cnt <= '0;
                    end else if (w_scan_done) begin
                        r_col <= r_col + 2'd1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    // Abort leaves the column as is; scanning resumes with a fresh dwell.
                    if (!w_row_held || w_deb_done) r_cnt <= '0;
                    else                           r_cnt <= r_cnt + 1'b1;
                end
                ST_EMIT: begin
                    if (w_hold_done) r_cnt <= '0;
                    else             r_cnt <= r_cnt + 1'b1;
                end
                ST_RELEASE: begin
                    if (!w_all_high) begin
                        r_cnt <= '0;
                    end else if (w_deb_done) begin
                        r_cnt <= '0;
                        r_col <= r_col + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_cols      = ~(4'b0001 << r_col);
    assign o_cmd       = r_cmd;
    assign o_cmd_valid = r_cmd_valid;

endmodule

// File: tb/tb_calc_keypad.sv
// tb_calc_keypad: randomized self-checking bench for calc_keypad with a
// behavioural keypad (rows resolved from cols and the set of held keys)
// and a run-level observer of cmd / cmd_valid.
`timescale 1ns/100ps
module tb_calc_keypad;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 15;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [3:0][3:0] keys = '0;   // keys[row][col] = 1 while held

    int n_chk  = 0;
    int n_fail = 0;

    always #1 clk = ~clk;

    // A held key shorts its row to its column; rows idle high.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !cols[c]) rows[r] = 1'b0;
    end

    calc_keypad #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rows      (rows),
        .o_cols      (cols),
        .o_cmd       (cmd),
        .o_cmd_valid (cmd_valid)
    );

    // Observer: collects each non-idle cmd run (code, length), counts
    // cmd_valid pulses and flags pulses not on the first cycle of a run.
    int         cyc = 0;
    int         n_valid = 0;
    int         n_bad = 0;
    int         valid_cyc = 0;
    int         run_len = 0;
    logic [3:0] prev = 4'hF;
    logic [3:0] run_code = 4'hF;
    int         got_code[$];
    int         got_len[$];
    int         exp_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            prev    = 4'hF;
            run_len = 0;
        end else begin
            if (cmd_valid) begin
                n_valid   = n_valid + 1;
                valid_cyc = cyc;
            end
            if (cmd != 4'hF) begin
                if (prev == 4'hF || cmd != prev) begin
                    if (prev != 4'hF) begin
                        got_code.push_back(int'(run_code));
                        got_len.push_back(run_len);
                    end
                    run_code = cmd;
                    run_len  = 1;
                    if (!cmd_valid) n_bad = n_bad + 1;
                end else begin
                    run_len = run_len + 1;
                    if (cmd_valid) n_bad = n_bad + 1;
                end
            end else begin
                if (cmd_valid) n_bad = n_bad + 1;
                if (prev != 4'hF) begin
                    got_code.push_back(int'(run_code));
                    got_len.push_back(run_len);
                end
            end
            prev = cmd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_code.delete();
        got_len.delete();
        exp_q.delete();
        n_valid   = 0;
        n_bad     = 0;
        valid_cyc = 0;
    endtask

    // Reference key map from the keypad legend; -1 means the key has no command.
    function automatic int ref_code(input int r, input int c);
        string lbl = "123A456B789CD0E-";
        byte   ch;
        ch = lbl[r*4 + c];
        if (ch >= 8'h30 && ch <= 8'h39) return int'(ch) - 48;
        if (ch >= 8'h41 && ch <= 8'h45) return int'(ch) - 65 + 10;
        return -1;
    endfunction

    task automatic tap(input int r, input int c, input int hold, input int gap);
        if (ref_code(r, c) >= 0) exp_q.push_back(ref_code(r, c));
        keys[r][c] = 1'b1;
        cycles(hold);
        keys[r][c] = 1'b0;
        cycles(gap);
    endtask

    task automatic finish_scn(input string tag);
        int n;
        chk({tag, ".valid_cnt"}, n_valid, exp_q.size());
        chk({tag, ".run_cnt"}, got_code.size(), exp_q.size());
        chk({tag, ".stray_valid"}, n_bad, 0);
        n = (got_code.size() < exp_q.size()) ? got_code.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.code%0d", tag, i), got_code[i], exp_q[i]);
            chk($sformatf("%s.len%0d", tag, i), got_len[i], HOLD);
        end
        clear_obs();
    endtask

    initial begin
        logic [3:0] exp_cols;
        int         t;
        int         s;

        // Reset state and idle column rotation
        cycles(3);
        chk("rst.cols", cols, 4'b1110);
        chk("rst.cmd", cmd, 4'hF);
        chk("rst.valid", cmd_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            exp_cols = ~(4'b0001 << ((i / SCAN) % 4));
            chk($sformatf("rot%0d", i), cols, exp_cols);
            cycles(1);
        end
        chk("idle.cmd", cmd, 4'hF);
        clear_obs();

        // Single key held long: one command only
        tap(0, 1, 100, 60);
        finish_scn("hold_r0c1");

        // Sequence 1, 2, A, 3, E with releases
        tap(0, 0, $urandom_range(35, 70), $urandom_range(40, 60));
        tap(0, 1, $urandom_range(35, 70), $urandom_range(40, 60));
        tap(0, 3, $urandom_range(35, 70), $urandom_range(40, 60));
        tap(0, 2, $urandom_range(35, 70), $urandom_range(40, 60));
        tap(3, 2, $urandom_range(35, 70), $urandom_range(40, 60));
        finish_scn("seq");

        // Bouncing contact, then stable
        exp_q.push_back(ref_code(1, 2));
        for (int i = 0; i < 40; i++) begin
            keys[1][2] = ((i / 3) % 2 == 0);
            cycles(1);
        end
        keys[1][2] = 1'b1;
        s = cyc;
        cycles(60);
        keys[1][2] = 1'b0;
        cycles(50);
        chk("bounce.stable_wait", ((valid_cyc - s) >= DEB), 1);
        finish_scn("bounce");

        // Two rows in one column: ignored
        keys[0][0] = 1'b1;
        keys[1][0] = 1'b1;
        cycles(80);
        keys[0][0] = 1'b0;
        keys[1][0] = 1'b0;
        cycles(40);
        finish_scn("double");

        // Unused key: no command, then scanning recovers
        tap(3, 3, 80, 50);
        finish_scn("unused");
        tap(1, 1, 60, 50);
        finish_scn("recover");

        // Random keys
        for (int k = 0; k < 8; k++)
            tap($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(35, 70), $urandom_range(40, 60));
        finish_scn("rand");

        // Reset on the 5th EMIT clock of key 7
        keys[2][0] = 1'b1;
        t = 0;
        while (cmd !== 4'd7 && t < 200) begin
            cycles(1);
            t++;
        end
        chk("rst_emit.reach", (t < 200), 1);
        cycles(4);
        rst_n = 1'b0;
        #0.2;
        chk("rst_emit.cmd", cmd, 4'hF);
        chk("rst_emit.cols", cols, 4'b1110);
        chk("rst_emit.valid", cmd_valid, 0);
        clear_obs();
        keys[2][0] = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(60);
        finish_scn("post_rst");
        tap(2, 0, 60, 50);
        finish_scn("fresh7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
